// File: rtl/pcie_dma_burst_rd.sv
// Burst reader between the video FIFO read side and the PCIe DMA engine.
// When a full burst is buffered it issues a DMA write request, then streams the burst out through a 2-entry skid buffer.
// Define DMA_UNDERRUN_CHK_EN to build the sticky err_underrun detector.
module pcie_dma_burst_rd #(
  parameter int                    DATA_WIDTH  = 128,
  parameter int                    LEVEL_WIDTH = 11,
  parameter int                    BURST_LEN   = 16,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h1000_0000,
  parameter int                    FRAME_WORDS = 115200
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [ADDR_WIDTH-1:0]  req_addr,
  output logic [7:0]             req_len,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   err_underrun
);

  localparam int FRAMES = FRAME_WORDS / BURST_LEN;
  localparam int BCW    = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [BCW-1:0]         bcnt_q, bcnt_d;
  logic [7:0]             issued_q, issued_d, beat_q, beat_d;
  logic                   inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   frame_done_q, frame_done_d;
  logic                   pop, space, want, rd_en, last_acc;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    bcnt_d       = bcnt_q;
    issued_d     = issued_q;
    beat_d       = beat_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;

    pop      = (cnt_q != 2'd0) && m_ready;
    // Occupancy after this cycle (stored + in flight - popped) must stay below 2.
    space    = ({1'b0, cnt_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
    want     = (state_q == DATA) && (issued_q < 8'(BURST_LEN)) && space;
    rd_en    = want && !fifo_rd_empty;
    last_acc = (state_q == DATA) && pop && (beat_q == 8'(BURST_LEN - 1));
    inflight_d = rd_en;

    unique case (state_q)
      IDLE: if (enable && (fifo_rd_water_level >= LEVEL_WIDTH'(BURST_LEN))) state_d = REQ;
      REQ: if (req_ready) begin
        state_d  = DATA;
        issued_d = 8'd0;
        beat_d   = 8'd0;
      end
      DATA: begin
        issued_d = issued_q + 8'(rd_en);
        if (pop) beat_d = beat_q + 8'd1;
        if (last_acc) begin
          state_d  = IDLE;
          issued_d = 8'd0;
          beat_d   = 8'd0;
          if (bcnt_q == BCW'(FRAMES - 1)) begin
            bcnt_d       = '0;
            addr_d       = BASE_ADDR;
            frame_done_d = 1'b1;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
            addr_d = addr_q + ADDR_WIDTH'(BURST_LEN * 16);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Skid buffer: buf0 is always the oldest entry.
    unique case ({inflight_q, pop})
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = fifo_rd_data;
        else               buf1_d = fifo_rd_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) buf0_d = fifo_rd_data;
        else begin
          buf0_d = buf1_q;
          buf1_d = fifo_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= BASE_ADDR;
      bcnt_q       <= '0;
      issued_q     <= 8'd0;
      beat_q       <= 8'd0;
      inflight_q   <= 1'b0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      cnt_q        <= 2'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      bcnt_q       <= bcnt_d;
      issued_q     <= issued_d;
      beat_q       <= beat_d;
      inflight_q   <= inflight_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign req_valid  = (state_q == REQ);
  assign req_addr   = addr_q;
  assign req_len    = (state_q == REQ) ? 8'(BURST_LEN) : 8'd0;
  assign m_valid    = (cnt_q != 2'd0);
  assign m_data     = buf0_q;
  assign m_last     = m_valid && (beat_q == 8'(BURST_LEN - 1));
  assign frame_done = frame_done_q;
  assign busy       = (state_q != IDLE);

`ifdef DMA_UNDERRUN_CHK_EN
  logic err_q, err_d, en_q;

  // A rising edge of enable is the software clear for the sticky flag.
  always_comb begin
    err_d = err_q;
    if (enable && !en_q)           err_d = 1'b0;
    else if (want && fifo_rd_empty) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      err_q <= err_d;
      en_q  <= enable;
    end
  end

  assign err_underrun = err_q;
`else
  assign err_underrun = 1'b0;
`endif

endmodule

// File: tb/tb_pcie_dma_burst_rd.sv
// Scoreboard bench for pcie_dma_burst_rd: FIFO model feeds words, expected words/addresses are queued at push time.
// Covers level gating, latency, backpressure, frame wrap, enable drop, forced empty and mid-burst reset.
module tb_pcie_dma_burst_rd;
  localparam int DW = 128, LW = 11, BL = 16, AW = 32, FW = 32;
  localparam logic [AW-1:0] BASE = 32'h1000_0000;
`ifdef DMA_UNDERRUN_CHK_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, req_ready = 1'b0, m_ready = 1'b0, force_empty = 1'b0;
  logic fifo_rd_en, fifo_rd_empty, req_valid, m_valid, m_last, frame_done, busy, err_underrun;
  logic [DW-1:0] fifo_rd_data = '0, m_data;
  logic [LW-1:0] lvl = '0;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;

  assign fifo_rd_empty = (lvl == '0) || force_empty;
  always #5 clk = ~clk;

  pcie_dma_burst_rd #(
    .DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .BURST_LEN(BL), .ADDR_WIDTH(AW),
    .BASE_ADDR(BASE), .FRAME_WORDS(FW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_water_level(lvl),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .frame_done(frame_done), .busy(busy), .err_underrun(err_underrun)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] wval(input int k);
    return {64'(k) ^ 64'hA5A5_0000_0000_0000, 64'(k)};
  endfunction

  // Stimulus-owned controls
  int n_push = 0, flush_gen = 0, n_ea = 0;
  bit chk_lat = 1'b0;
  logic [AW-1:0] exp_addr [0:15];

  // Model/monitor-owned state
  logic [127:0] fifo_q [$];
  logic [127:0] exp_q  [$];
  int cyc = 0, pushed = 0, flush_done = 0, ai = 0;
  int bi = 0, beats_tot = 0, rd_cnt = 0, fd_cnt = 0, hs_cyc = 0, c0 = 0;
  bit stall = 1'b0, rstall = 1'b0;
  logic [127:0] held_d;
  logic held_l;
  logic [AW-1:0] held_a;

  // FIFO model (posedge) and output monitor/scoreboard (negedge) in one process.
  initial begin
    forever begin
      @(clk);
      if (clk) begin
        cyc++;
        if (fifo_rd_en) begin
          if (fifo_q.size() == 0) chk("fifo_pop_empty", 1, 0);
          else fifo_rd_data <= fifo_q.pop_front();
        end
      end else begin
        if (flush_done != flush_gen) begin
          fifo_q.delete();
          exp_q.delete();
          flush_done = flush_gen;
        end
        while (pushed < n_push) begin
          fifo_q.push_back(wval(pushed));
          exp_q.push_back(wval(pushed));
          pushed++;
        end
        lvl = LW'(fifo_q.size());
        if (!rst_n) begin
          bi = 0; stall = 1'b0; rstall = 1'b0;
        end else begin
          if (fifo_rd_en) rd_cnt++;
          if (frame_done) fd_cnt++;
          if (rstall) chk("req_addr_hold", req_addr, held_a);
          if (req_valid && req_ready) begin
            if (ai >= n_ea) chk("unexpected_req", 1, 0);
            else begin
              chk("req_addr", req_addr, exp_addr[ai]);
              ai++;
            end
            chk("req_len", req_len, BL);
            hs_cyc = cyc + 1;  // cycle index of the edge that accepts the request
          end
          rstall = req_valid && !req_ready;
          held_a = req_addr;
          if (stall) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, held_d);
            chk("hold_last", m_last, held_l);
          end
          if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else chk("beat_data", m_data, exp_q.pop_front());
            chk("beat_last", m_last, bi == BL - 1);
            if (chk_lat && bi == 0) begin
              chk("first_beat_lat", cyc - hs_cyc, 2);
              c0 = cyc;
            end
            if (chk_lat && bi == BL - 1) chk("beats_consecutive", cyc - c0, BL - 1);
            bi = (bi + 1) % BL;
            beats_tot++;
          end
          stall = m_valid && !m_ready;
          held_d = m_data;
          held_l = m_last;
        end
      end
    end
  end

  // Drives one burst; returns early once rst_at beats are accepted.
  task automatic run_burst(input bit bp, input int drop_at, input int rst_at, input int empty_at);
    int b0 = beats_tot;
    int ef = 0;
    bit seen_busy = 1'b0, rv_seen = 1'b0, done = 1'b0, ef_used = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      req_ready = req_valid && rv_seen;
      rv_seen   = req_valid;
      m_ready   = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (drop_at >= 0 && beats_tot - b0 >= drop_at) enable = 1'b0;
      if (empty_at >= 0 && !ef_used && beats_tot - b0 >= empty_at) begin
        ef = 3; ef_used = 1'b1;
      end
      force_empty = (ef > 0);
      if (ef > 0) ef--;
      if (rst_at >= 0 && beats_tot - b0 >= rst_at) begin
        req_ready = 1'b0;
        return;
      end
      if (busy) seen_busy = 1'b1;
      if (seen_busy && !busy) begin
        done = 1'b1;
        break;
      end
    end
    req_ready = 1'b0;
    force_empty = 1'b0;
    m_ready = 1'b1;
    if (!done) chk("burst_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int r0, b0;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_misc", {m_last, frame_done, busy, err_underrun}, 0);
    chk("rst_req_len", req_len, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_req_addr", req_addr, BASE);

    rst_n = 1'b1; enable = 1'b1; m_ready = 1'b1;
    n_push = 15;
    seen = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      seen |= req_valid | fifo_rd_en;
    end
    chk("gate_level15", seen, 0);
    exp_addr[n_ea++] = BASE;
    n_push = 16;
    @(posedge clk); #1;
    chk("gate_req_valid", req_valid, 1);
    chk("gate_req_addr", req_addr, BASE);
    chk("gate_req_len", req_len, BL);

    // Burst 1: late req_ready, full-rate drain
    chk_lat = 1'b1; r0 = rd_cnt; b0 = beats_tot;
    run_burst(1'b0, -1, -1, -1);
    chk_lat = 1'b0;
    chk("b1_rd_en_count", rd_cnt - r0, BL);
    chk("b1_beats", beats_tot - b0, BL);
    chk("b1_idle", busy, 0);

    // Burst 2: random backpressure, ends the 2-burst frame
    exp_addr[n_ea++] = BASE + 32'h100;
    n_push += 16; b0 = beats_tot;
    run_burst(1'b1, -1, -1, -1);
    chk("b2_beats", beats_tot - b0, BL);
    chk("b2_frame_done", fd_cnt, 1);

    // Burst 3: wrapped address, enable dropped at beat 5
    exp_addr[n_ea++] = BASE;
    n_push += 16; b0 = beats_tot;
    run_burst(1'b0, 5, -1, -1);
    chk("b3_beats", beats_tot - b0, BL);
    n_push += 16;
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      seen |= req_valid;
    end
    chk("disabled_no_req", seen, 0);
    chk("b3_no_frame_done", fd_cnt, 1);

    // Reset at beat 7 of the next burst
    exp_addr[n_ea++] = BASE + 32'h100;
    enable = 1'b1;
    run_burst(1'b0, -1, 7, -1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {req_valid, fifo_rd_en, m_valid, m_last, busy, frame_done, err_underrun}, 0);
    chk("midrst_addr", req_addr, BASE);
    flush_gen++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_addr[n_ea++] = BASE;
    n_push += 16; b0 = beats_tot;
    run_burst(1'b0, -1, -1, -1);
    chk("post_rst_beats", beats_tot - b0, BL);
    chk("err_before_empty", err_underrun, 0);

    // Forced empty for 3 cycles mid-burst
    exp_addr[n_ea++] = BASE + 32'h100;
    n_push += 16; b0 = beats_tot;
    run_burst(1'b0, -1, -1, 4);
    chk("empty_beats", beats_tot - b0, BL);
    chk("underrun_flag", err_underrun, UR_EN);
    chk("frame_done_total", fd_cnt, 2);
    enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    chk("underrun_clear", err_underrun, 0);
    chk("reqs_all_seen", ai, n_ea);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
